// File: rtl/keystroke_pkg.sv
// Shared constants and width helpers for the keystroke conditioner.
// Optional auto-repeat is enabled with `define KEY_AUTOREPEAT_EN.
package keystroke_pkg;

  localparam int unsigned N_KEYS_DEF = 12;

  // Bit positions on the core's keystroke bus.
  localparam int unsigned KEY_MODE0   = 1;
  localparam int unsigned KEY_MODE1   = 3;
  localparam int unsigned KEY_MODE2   = 5;
  localparam int unsigned KEY_MODE3   = 7;
  localparam int unsigned KEY_CONFIRM = 8;
  localparam int unsigned KEY_RUN     = 9;

  // Width of a counter that must hold 0..n-1. Never returns less than 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// One keystroke bit: two-flop synchroniser, tick-driven debounce counter, and registered strobes.
// Auto-repeat logic is built only when KEY_AUTOREPEAT_EN is defined.
module key_debounce_bit
  import keystroke_pkg::*;
#(
  parameter int unsigned DEB_TICKS     = 8,
  parameter int unsigned REPEAT_DELAY  = 500,
  parameter int unsigned REPEAT_PERIOD = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic event_d_o
);

  localparam int unsigned   CW       = cnt_width(DEB_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_TICKS - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic          repeat_fire;

  // A single mismatch-free tick discards all progress.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cnt_d   = cnt_q;
    level_d = level_q;
    accept  = 1'b0;
    if (tick_i) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q >= CNT_LAST) begin
        cnt_d   = '0;
        level_d = ~level_q;
        accept  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned   RPT_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                       : REPEAT_PERIOD;
  localparam int unsigned   RW        = cnt_width(RPT_MAX);
  localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_q, rpt_d;
  logic          rpt_armed_q, rpt_armed_d;

  // armed marks that the initial delay has elapsed and the shorter period now applies.
  // The repeat count restarts on any accepted transition, so a release edge never repeats.
  always_comb begin
    rpt_d       = rpt_q;
    rpt_armed_d = rpt_armed_q;
    repeat_fire = 1'b0;
    if (!level_q || accept) begin
      rpt_d       = '0;
      rpt_armed_d = 1'b0;
    end else if (tick_i) begin
      if (rpt_q >= (rpt_armed_q ? RPT_NEXT : RPT_FIRST)) begin
        repeat_fire = 1'b1;
        rpt_d       = '0;
        rpt_armed_d = 1'b1;
      end else begin
        rpt_d = rpt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_q       <= '0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_q       <= rpt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  assign press_d   = (accept & level_d) | repeat_fire;
  assign release_d = accept & ~level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let sync1 -> sync2 shift correctly within one edge.
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign event_d_o = press_d | release_d;

endmodule

// File: rtl/keystroke_conditioner.sv
// Synchronises and debounces the raw key pins into clean levels and edge strobes for the core.
// Define KEY_AUTOREPEAT_EN to add held-key auto-repeat on key_press.
module keystroke_conditioner
  import keystroke_pkg::*;
#(
  parameter int unsigned N_KEYS        = N_KEYS_DEF,
  parameter int unsigned TICK_DIV      = 100000,
  parameter int unsigned DEB_TICKS     = 8,
  parameter int unsigned REPEAT_DELAY  = 500,
  parameter int unsigned REPEAT_PERIOD = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] keystroke,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              key_change
);

  logic              tick;
  logic [N_KEYS-1:0] evt_d;
  logic              key_change_q;

  // One shared sample tick; a divide of 1 makes every cycle a tick.
  generate
    if (TICK_DIV <= 1) begin : g_no_div
      assign tick = 1'b1;
    end else begin : g_div
      localparam int unsigned   PW       = cnt_width(TICK_DIV);
      localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
      logic [PW-1:0] pre_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                pre_q <= '0;
        else if (pre_q == PRE_LAST) pre_q <= '0;
        else                       pre_q <= pre_q + 1'b1;
      end

      assign tick = (pre_q == PRE_LAST);
    end
  endgenerate

  generate
    for (genvar i = 0; i < N_KEYS; i++) begin : g_bit
      key_debounce_bit #(
        .DEB_TICKS     (DEB_TICKS),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_bit (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_i    (tick),
        .raw_i     (key_raw[i]),
        .level_o   (keystroke[i]),
        .press_o   (key_press[i]),
        .release_o (key_release[i]),
        .event_d_o (evt_d[i])
      );
    end
  endgenerate

  // Registered from the per-bit next-state strobes so it lines up with key_press/key_release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_change_q <= 1'b0;
    else        key_change_q <= |evt_d;
  end

  assign key_change = key_change_q;

endmodule

// File: tb/tb_keystroke_conditioner.sv
// Directed bench for keystroke_conditioner with TICK_DIV=1, DEB_TICKS=4.
// Repeat expectations follow KEY_AUTOREPEAT_EN (REPEAT_DELAY=10, REPEAT_PERIOD=5).
`timescale 1ns/1ps
module tb_keystroke_conditioner;
  import keystroke_pkg::*;

  localparam int unsigned NK = 12;
  localparam logic [NK-1:0] B8 = NK'(1) << KEY_CONFIRM;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_raw = '0;
  logic [NK-1:0] keystroke, key_press, key_release;
  logic          key_change;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  keystroke_conditioner #(
    .N_KEYS        (NK),
    .TICK_DIV      (1),
    .DEB_TICKS     (4),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_raw     (key_raw),
    .keystroke   (keystroke),
    .key_press   (key_press),
    .key_release (key_release),
    .key_change  (key_change)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_to(input logic [NK-1:0] raw);
    rst_n   = 1'b0;
    key_raw = raw;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();
  endtask

  function automatic logic exp_repeat(input int e);
`ifdef KEY_AUTOREPEAT_EN
    return (e >= 16) && (e < 46) && (((e - 16) % 5) == 0);
`else
    return (e < 0);
`endif
  endfunction

  initial begin
    int n_press, n_rel, n_chg;
    logic [NK-1:0] ks_exp;

    // 1: reset with all keys held; first acceptance lands on the 6th edge after release.
    key_raw = '1;
    rst_n   = 1'b0;
    repeat (10) step();
    check("t1 rst keystroke", keystroke, 0);
    check("t1 rst press", key_press, 0);
    check("t1 rst release", key_release, 0);
    check("t1 rst change", key_change, 0);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      check($sformatf("t1 ks e%0d", e), keystroke, (e >= 6) ? 12'hFFF : 12'h000);
      check($sformatf("t1 press e%0d", e), key_press, (e == 6) ? 12'hFFF : 12'h000);
      check($sformatf("t1 chg e%0d", e), key_change, (e == 6));
    end

    // 2: clean 5-cycle pulse on the confirm bit.
    reset_to('0);
    n_press = 0; n_rel = 0; n_chg = 0;
    for (int e = 1; e <= 14; e++) begin
      key_raw = (e <= 5) ? B8 : '0;
      step();
      ks_exp = (e >= 6 && e < 11) ? B8 : '0;
      check($sformatf("t2 ks e%0d", e), keystroke, ks_exp);
      check($sformatf("t2 press e%0d", e), key_press, (e == 6) ? B8 : '0);
      check($sformatf("t2 rel e%0d", e), key_release, (e == 11) ? B8 : '0);
      n_press += int'(key_press[KEY_CONFIRM]);
      n_rel   += int'(key_release[KEY_CONFIRM]);
      n_chg   += int'(key_change);
    end
    check("t2 press count", n_press, 1);
    check("t2 release count", n_rel, 1);
    check("t2 change count", n_chg, 2);

    // 3: 3-cycle bounces on the run bit never reach DEB_TICKS.
    reset_to('0);
    for (int e = 1; e <= 16; e++) begin
      key_raw = '0;
      key_raw[KEY_RUN] = (e <= 3) || (e > 6 && e <= 9);
      step();
      check($sformatf("t3 ks e%0d", e), keystroke, 0);
      check($sformatf("t3 chg e%0d", e), key_change, 0);
    end

    // 4: bit7 falls and bit5 rises on the same cycle.
    reset_to(12'h082);
    check("t4 settled", keystroke, 12'h082);
    key_raw = 12'h022;
    n_chg = 0;
    for (int e = 1; e <= 9; e++) begin
      step();
      check($sformatf("t4 ks e%0d", e), keystroke, (e >= 6) ? 12'h022 : 12'h082);
      check($sformatf("t4 press e%0d", e), key_press, (e == 6) ? 12'h020 : 12'h000);
      check($sformatf("t4 rel e%0d", e), key_release, (e == 6) ? 12'h080 : 12'h000);
      n_chg += int'(key_change);
    end
    check("t4 change count", n_chg, 1);

    // 5: asynchronous reset mid-count clears outputs at once and discards progress.
    reset_to(12'h001);
    key_raw = 12'h009;
    repeat (4) step();
    check("t5 pre ks", keystroke, 12'h001);
    #1 rst_n = 1'b0;
    #1;
    check("t5 async ks", keystroke, 0);
    check("t5 async press", key_press, 0);
    check("t5 async change", key_change, 0);
    #2 rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      check($sformatf("t5 ks e%0d", e), keystroke, (e >= 6) ? 12'h009 : 12'h000);
      check($sformatf("t5 press e%0d", e), key_press, (e == 6) ? 12'h009 : 12'h000);
    end

    // 6: confirm held 40 cycles; repeats appear only when auto-repeat is built in.
    reset_to('0);
    n_press = 0;
    for (int e = 1; e <= 60; e++) begin
      key_raw = (e <= 40) ? B8 : '0;
      step();
      check($sformatf("t6 ks e%0d", e), keystroke, (e >= 6 && e < 46) ? B8 : '0);
      check($sformatf("t6 press e%0d", e), key_press,
            ((e == 6) || exp_repeat(e)) ? B8 : '0);
      check($sformatf("t6 rel e%0d", e), key_release, (e == 46) ? B8 : '0);
      check($sformatf("t6 chg e%0d", e), key_change,
            (e == 6) || (e == 46) || exp_repeat(e));
      n_press += int'(key_press[KEY_CONFIRM]);
    end
`ifdef KEY_AUTOREPEAT_EN
    check("t6 press count", n_press, 7);
`else
    check("t6 press count", n_press, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
